// File: rtl/attack_link_sequencer.sv
// Turn sequencer for one player's board: validates and sends the local
// attack with ack/timeout/retry, then validates the opponent's reply.
module attack_link_sequencer #(
  parameter int   W              = 16,
  parameter int   TIMEOUT_CYCLES = 100_000_000,
  parameter int   MAX_RETRY      = 3,
  parameter logic FIRST_TURN     = 1'b1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         fire,
  input  logic [W-1:0] attack_in,
  input  logic         tx_busy,
  input  logic         rx_ack,
  input  logic         rx_valid,
  input  logic [W-1:0] rx_data,
  output logic         tx_start,
  output logic [W-1:0] tx_data,
  output logic         ld_attack,
  output logic         rx_accept,
  output logic [W-1:0] rx_map,
  output logic         reject,
  output logic         my_turn,
  output logic [2:0]   state_code,
  output logic         err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ?
                      $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    TXWAIT  = 3'd2,
    ACKWAIT = 3'd3,
    OPP     = 3'd4,
    ERROR   = 3'd7
  } state_e;

  // Legal move: nothing erased and exactly one cell added.
  function automatic logic one_new(
    input logic [W-1:0] prev,
    input logic [W-1:0] x
  );
    logic [W-1:0] n;
    n = x & ~prev;
    return ((prev & ~x) == '0) && (n != '0) &&
           ((n & (n - W'(1))) == '0);
  endfunction

  state_e         state_q, state_d;
  logic [W-1:0]   tx_data_q, tx_data_d;
  logic [W-1:0]   rx_map_q, rx_map_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           seen_q, seen_d;
  logic           my_turn_q, my_turn_d;
  logic           err_q, err_d;
  logic           tx_start_q, tx_start_d;
  logic           ld_q, ld_d;
  logic           acc_q, acc_d;
  logic           rej_q, rej_d;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    rx_map_d   = rx_map_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    seen_d     = seen_q;
    my_turn_d  = my_turn_q;
    err_d      = err_q;
    tx_start_d = 1'b0;
    ld_d       = 1'b0;
    acc_d      = 1'b0;
    rej_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (one_new(tx_data_q, attack_in)) begin
            tx_data_d = attack_in;
            ld_d      = 1'b1;
            state_d   = SEND;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          seen_d     = 1'b0;
          state_d    = TXWAIT;
        end
      end
      TXWAIT: begin
        // Leave only on the busy falling edge of our own frame.
        if (tx_busy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          timer_d = '0;
          state_d = ACKWAIT;
        end
      end
      ACKWAIT: begin
        timer_d = timer_q + TW'(1);
        if (rx_ack) begin
          retry_d   = '0;
          my_turn_d = 1'b0;
          state_d   = OPP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            my_turn_d = 1'b0;
            err_d     = 1'b1;
            state_d   = ERROR;
          end
        end
      end
      OPP: begin
        if (rx_valid) begin
          if (one_new(rx_map_q, rx_data)) begin
            rx_map_d  = rx_data;
            acc_d     = 1'b1;
            my_turn_d = 1'b1;
            state_d   = IDLE;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ERROR: begin
        my_turn_d = 1'b0;
        err_d     = 1'b1;
      end
      default: begin
        my_turn_d = 1'b0;
        err_d     = 1'b1;
        state_d   = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= FIRST_TURN ? IDLE : OPP;
      tx_data_q  <= '0;
      rx_map_q   <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      seen_q     <= 1'b0;
      my_turn_q  <= FIRST_TURN;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      ld_q       <= 1'b0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      rx_map_q   <= rx_map_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      seen_q     <= seen_d;
      my_turn_q  <= my_turn_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      ld_q       <= ld_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign ld_attack  = ld_q;
  assign rx_accept  = acc_q;
  assign rx_map     = rx_map_q;
  assign reject     = rej_q;
  assign my_turn    = my_turn_q;
  assign state_code = state_q;
  assign err        = err_q;

endmodule

// File: tb/tb_attack_link_sequencer.sv
// Randomized turn-exchange bench for attack_link_sequencer with a
// transaction-level board model and cycle-count timing expectations.
module tb_attack_link_sequencer;

  localparam int W  = 16;
  localparam int TO = 20;
  localparam int MR = 3;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         fire;
  logic [W-1:0] attack_in;
  logic         tx_busy;
  logic         rx_ack;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         tx_start;
  logic [W-1:0] tx_data;
  logic         ld_attack;
  logic         rx_accept;
  logic [W-1:0] rx_map;
  logic         reject;
  logic         my_turn;
  logic [2:0]   state_code;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] m_tx;
  logic [W-1:0] m_rx;

  attack_link_sequencer #(
    .W(W),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR),
    .FIRST_TURN(1'b1)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .fire(fire),
    .attack_in(attack_in),
    .tx_busy(tx_busy),
    .rx_ack(rx_ack),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .ld_attack(ld_attack),
    .rx_accept(rx_accept),
    .rx_map(rx_map),
    .reject(reject),
    .my_turn(my_turn),
    .state_code(state_code),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit legal(input logic [W-1:0] prev,
                               input logic [W-1:0] x);
    return ((prev & ~x) == '0) &&
           ($countones(x & ~prev) == 1);
  endfunction

  function automatic logic [W-1:0] add_cell(input logic [W-1:0] m);
    int i;
    if (m == '1) return m;
    do i = $urandom_range(W - 1, 0); while (m[i]);
    return m | (W'(1) << i);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    fire     = 1'b0;
    rx_ack   = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_state", state_code, 0);
    chk("rst_turn", my_turn, 1);
    chk("rst_txd", tx_data, 0);
    chk("rst_map", rx_map, 0);
    chk("rst_err", err, 0);
    chk("rst_pulses", {tx_start, ld_attack, rx_accept, reject}, 0);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    cyc();
    clr_n = 1'b1;
    m_tx  = '0;
    m_rx  = '0;
    chk_reset();
  endtask

  task automatic try_fire(input logic [W-1:0] x, input bit with_rx);
    fire      = 1'b1;
    attack_in = x;
    if (with_rx) begin
      rx_valid = 1'b1;
      rx_data  = add_cell(m_rx);
    end
    cyc();
    chk("idle_rxacc", rx_accept, 0);
    chk("idle_map", rx_map, m_rx);
    if (legal(m_tx, x)) begin
      m_tx = x;
      chk("fire_ld", ld_attack, 1);
      chk("fire_txd", tx_data, m_tx);
      chk("fire_state", state_code, 1);
    end else begin
      chk("bad_rej", reject, 1);
      chk("bad_ld", ld_attack, 0);
      chk("bad_state", state_code, 0);
      chk("bad_txd", tx_data, m_tx);
    end
  endtask

  task automatic send_phase(input int hold);
    int b;
    tx_busy = 1'b1;
    repeat (hold) cyc();
    if (hold > 0) begin
      chk("hold_state", state_code, 1);
      chk("hold_start", tx_start, 0);
    end
    tx_busy = 1'b0;
    cyc();
    chk("start", tx_start, 1);
    chk("start_state", state_code, 2);
    chk("start_txd", tx_data, m_tx);
    repeat ($urandom_range(2, 0)) cyc();
    chk("txw_pre", state_code, 2);
    tx_busy = 1'b1;
    b = $urandom_range(4, 1);
    repeat (b) cyc();
    chk("txw_busy", state_code, 2);
    chk("txw_nostart", tx_start, 0);
    tx_busy = 1'b0;
    cyc();
    chk("ackw_enter", state_code, 3);
  endtask

  task automatic ack_phase(input int timeouts, input int d,
                           output bit errored);
    errored = 1'b0;
    for (int t = 0; t < timeouts; t++) begin
      fire      = 1'b1;
      attack_in = add_cell(m_tx);
      rx_valid  = 1'b1;
      rx_data   = add_cell(m_rx);
      cyc();
      chk("ackw_stray", {ld_attack, rx_accept, reject}, 0);
      repeat (TO - 2) cyc();
      chk("pre_timeout", state_code, 3);
      cyc();
      if (t == MR) begin
        chk("err_state", state_code, 7);
        chk("err_flag", err, 1);
        chk("err_turn", my_turn, 0);
        errored = 1'b1;
        return;
      end
      chk("resend_state", state_code, 1);
      send_phase($urandom_range(2, 0));
    end
    repeat (d) cyc();
    rx_ack = 1'b1;
    cyc();
    chk("ack_state", state_code, 4);
    chk("ack_turn", my_turn, 0);
  endtask

  task automatic opp_phase(input logic [W-1:0] x,
                           input int n_bad);
    logic [W-1:0] y;
    rx_ack    = 1'b1;
    fire      = 1'b1;
    attack_in = add_cell(m_tx);
    cyc();
    chk("opp_stray", {state_code, ld_attack, my_turn}, {3'd4, 2'b00});
    for (int k = 0; k < n_bad; k++) begin
      y = (k == 0 && m_rx == 16'h0030) ? 16'h0001 :
          m_rx | W'($urandom);
      if (legal(m_rx, y)) y = m_rx;
      rx_valid = 1'b1;
      rx_data  = y;
      cyc();
      chk("opp_rej", reject, 1);
      chk("opp_keep", rx_map, m_rx);
      chk("opp_stay", state_code, 4);
    end
    rx_valid = 1'b1;
    rx_data  = x;
    cyc();
    m_rx = x;
    chk("opp_acc", rx_accept, 1);
    chk("opp_map", rx_map, m_rx);
    chk("opp_turn", my_turn, 1);
    chk("opp_idle", state_code, 0);
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit e;
    int to;
    int d;
    clr_n     = 1'b0;
    fire      = 1'b0;
    attack_in = '0;
    tx_busy   = 1'b0;
    rx_ack    = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    @(negedge clk);

    // Full game: both boards fill up, last move 16'hFFFF.
    do_reset();
    for (int turn = 0; turn < W; turn++) begin
      if (turn == 1) begin
        try_fire(16'h0007, 1'b0);
        try_fire(16'h0002, 1'b0);
      end
      repeat ($urandom_range(2, 0)) begin
        case ($urandom_range(2, 0))
          0: x = m_tx | W'($urandom);
          1: x = m_tx;
          default: x = m_tx & ~(W'(1) << $urandom_range(W - 1, 0));
        endcase
        if (legal(m_tx, x)) x = m_tx;
        try_fire(x, 1'b0);
      end
      x = (turn == 0) ? 16'h0001 : add_cell(m_tx);
      try_fire(x, $urandom_range(1, 0) == 1);
      send_phase((turn == 2) ? 10 : $urandom_range(3, 0));
      to = (turn == 4) ? MR : $urandom_range(MR, 0);
      d  = (turn == 3 || turn == 4) ? TO - 1 : $urandom_range(TO - 1, 0);
      ack_phase(to, d, e);
      y = (turn == 0) ? 16'h0010 :
          (turn == 1) ? 16'h0030 : add_cell(m_rx);
      opp_phase(y, (turn == 2) ? 1 : $urandom_range(2, 0));
    end
    chk("full_txd", tx_data, 16'hFFFF);
    try_fire(16'hFFFF, 1'b0);

    // No ack ever: three resends then sticky ERROR.
    do_reset();
    try_fire(add_cell(m_tx), 1'b0);
    send_phase(0);
    ack_phase(MR + 1, 0, e);
    chk("err_reached", e, 1);
    fire      = 1'b1;
    attack_in = add_cell(m_tx);
    rx_ack    = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = add_cell(m_rx);
    repeat (3) cyc();
    chk("err_sticky", {state_code, err, my_turn}, {3'd7, 2'b10});
    chk("err_nopulse", {tx_start, ld_attack, rx_accept, reject}, 0);
    do_reset();

    // Reset lands mid-frame while the UART is still busy.
    try_fire(add_cell(m_tx), 1'b0);
    tx_busy = 1'b1;
    repeat (10) cyc();
    chk("busy_hold", {state_code, tx_start}, {3'd1, 1'b0});
    tx_busy = 1'b0;
    cyc();
    chk("late_start", tx_start, 1);
    tx_busy = 1'b1;
    repeat (3) cyc();
    chk("mid_txwait", state_code, 2);
    clr_n = 1'b0;
    cyc();
    clr_n   = 1'b1;
    tx_busy = 1'b0;
    m_tx    = '0;
    m_rx    = '0;
    chk_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
